// File: rtl/regfile_checker.sv
// regfile_checker: on-FPGA self-checking sequencer for the pipelined processor.
// It holds the processor in reset until started, then lets it run for a fixed
// number of cycles. It then walks a table of (register, expected value) pairs
// through a combinational regfile read port and reports the results.
//
// Handshake: there is no valid/ready pair. start is a level that is sampled
// only in IDLE or DONE. data_readReg must be valid combinationally from
// ctrl_readReg within the same cycle.
//
// Optional feature: define REGFILE_CHECKER_STOP_ON_FAIL_EN to end the CHECK
// phase at the first enabled mismatch.
module regfile_checker #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_CHECKS     = 6,
    parameter int CYCLE_LIMIT    = 60,
    parameter int CNT_WIDTH      = 16,
    parameter int ERR_WIDTH      = 8,
    localparam int IDX_WIDTH     = $clog2(NUM_CHECKS) + 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0] exp_reg,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]     exp_val,
    input  logic [NUM_CHECKS-1:0]                exp_en,
    output logic [REG_ADDR_WIDTH-1:0]            ctrl_readReg,
    input  logic [DATA_WIDTH-1:0]                data_readReg,
    output logic                                 proc_reset,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pass,
    output logic [ERR_WIDTH-1:0]                 error_count,
    output logic [IDX_WIDTH-1:0]                 first_fail_idx,
    output logic [DATA_WIDTH-1:0]                first_fail_value,
    output logic [CNT_WIDTH-1:0]                 cycle_count,
    output logic [1:0]                           state_dbg
);

    // A run limit of 0 still gives the processor one cycle out of reset.
    localparam int RUN_CYCLES = (CYCLE_LIMIT < 1) ? 1 : CYCLE_LIMIT;
    localparam logic [CNT_WIDTH-1:0] RUN_LAST = CNT_WIDTH'(RUN_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_CHECKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    restart_q;
    logic [CNT_WIDTH-1:0]    cycle_q;
    logic [IDX_WIDTH-1:0]    idx_q;
    logic [ERR_WIDTH-1:0]    err_q;
    logic [IDX_WIDTH-1:0]    ffi_q;
    logic [DATA_WIDTH-1:0]   ffv_q;

    logic [REG_ADDR_WIDTH-1:0] cur_reg;
    logic [DATA_WIDTH-1:0]     cur_val;
    logic                      cur_en;
    logic                      mismatch;

    // Select the table entry addressed by idx (mux form keeps index widths exact).
    always_comb begin
        cur_reg = '0;
        cur_val = '0;
        cur_en  = 1'b0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (idx_q == IDX_WIDTH'(i)) begin
                cur_reg = exp_reg[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                cur_val = exp_val[i*DATA_WIDTH +: DATA_WIDTH];
                cur_en  = exp_en[i];
            end
        end
    end

    assign mismatch = (state_q == ST_CHECK) && cur_en && (data_readReg != cur_val);

    // State register; restart_q remembers a restart from DONE so IDLE lasts one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            restart_q <= (state_q == ST_DONE) && start;
        end
    end

    // Next-state logic; start is ignored while RUN or CHECK is in progress.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start || restart_q) state_d = ST_RUN;
            ST_RUN:   if (cycle_q == RUN_LAST) state_d = ST_CHECK;
            ST_CHECK: begin
`ifdef REGFILE_CHECKER_STOP_ON_FAIL_EN
                if (mismatch || idx_q == IDX_LAST) state_d = ST_DONE;
`else
                if (idx_q == IDX_LAST) state_d = ST_DONE;
`endif
            end
            ST_DONE:  if (start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counters and result registers; results clear in IDLE and on a restart from DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            ffi_q   <= '1;
            ffv_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cycle_q <= '0;
                    idx_q   <= '0;
                    err_q   <= '0;
                    ffi_q   <= '1;
                    ffv_q   <= '0;
                end
                ST_RUN: begin
                    cycle_q <= cycle_q + 1'b1;
                    idx_q   <= '0;
                end
                ST_CHECK: begin
                    if (idx_q != IDX_LAST) idx_q <= idx_q + 1'b1;
                    if (mismatch) begin
                        if (err_q != '1) err_q <= err_q + 1'b1;
                        // err_q saturates and never wraps, so zero means no failure yet.
                        if (err_q == '0) begin
                            ffi_q <= idx_q;
                            ffv_q <= data_readReg;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        cycle_q <= '0;
                        idx_q   <= '0;
                        err_q   <= '0;
                        ffi_q   <= '1;
                        ffv_q   <= '0;
                    end
                end
                default: begin
                    cycle_q <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        proc_reset   = (state_q == ST_IDLE);
        busy         = (state_q == ST_RUN) || (state_q == ST_CHECK);
        done         = (state_q == ST_DONE);
        pass         = (state_q == ST_DONE) && (err_q == '0);
        ctrl_readReg = (state_q == ST_CHECK) ? cur_reg : '0;
        state_dbg    = state_q;
    end

    assign error_count      = err_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_value = ffv_q;
    assign cycle_count      = cycle_q;

endmodule

// File: doc/regfile_checker.md
# regfile_checker

Synthesizable self-checking test sequencer for the pipelined processor. It holds the processor in reset until started, then lets it run for a fixed number of cycles. After that it walks a parametrised table of (register, expected value) pairs through a regfile read port and reports pass/fail, an error count and the first failing entry. It sits beside `skeleton` on the FPGA, so directed processor tests can run on hardware with results shown on the LEDs.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register data width
- `REG_ADDR_WIDTH`, 5, register index width
- `NUM_CHECKS`, 6, number of table entries (≥1)
- `CYCLE_LIMIT`, 60, processor run cycles before checking (0 treated as 1)
- `CNT_WIDTH`, 16, run-cycle counter width (must hold CYCLE_LIMIT)
- `ERR_WIDTH`, 8, error counter width

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous active-high reset
- `start`  in  1  begin a test run; sampled only in IDLE or DONE
- `exp_reg`  in  NUM_CHECKS*REG_ADDR_WIDTH  entry i register index at bits [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
- `exp_val`  in  NUM_CHECKS*DATA_WIDTH  entry i expected value
- `exp_en`  in  NUM_CHECKS  entry i enable; a disabled entry is skipped but still consumes its cycle
- `ctrl_readReg`  out  REG_ADDR_WIDTH  regfile read index
- `data_readReg`  in  DATA_WIDTH  regfile read data, combinational from `ctrl_readReg`
- `proc_reset`  out  1  reset driven to the processor/skeleton
- `busy`  out  1  high in RUN and CHECK
- `done`  out  1  high in DONE
- `pass`  out  1  high in DONE when `error_count`==0
- `error_count`  out  ERR_WIDTH  mismatches, saturating
- `first_fail_idx`  out  $clog2(NUM_CHECKS)+1  index of the first mismatch
- `first_fail_value`  out  DATA_WIDTH  value read at the first mismatch
- `cycle_count`  out  CNT_WIDTH  run cycles elapsed

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE:
  - `proc_reset`=1; all counters are held at 0.
  - `start`=1 clears the results and moves to RUN.
- RUN:
  - `proc_reset`=0; `cycle_count` increments each cycle.
  - On the cycle `cycle_count`==max(CYCLE_LIMIT,1)-1, move to CHECK with idx=0.
- CHECK:
  - `ctrl_readReg`=`exp_reg[idx]`.
  - At each clock edge, if `exp_en[idx]` and `data_readReg`!=`exp_val[idx]`, increment `error_count` (saturating).
  - On the first such mismatch, also latch `first_fail_idx`=idx and `first_fail_value`=`data_readReg`.
  - idx increments each cycle. After idx==NUM_CHECKS-1, move to DONE.
  - The processor keeps running (`proc_reset`=0) through CHECK and DONE.
- DONE:
  - `done`=1; `pass`=(`error_count`==0); results hold.
  - `start`=1 restarts: state becomes IDLE-equivalent for one cycle, meaning `proc_reset`=1, then RUN.
- `start` during RUN or CHECK is ignored.
- `first_fail_idx` reads all-ones (value NUM_CHECKS or more is not used) when no failure occurred; `first_fail_value`=0 in that case.

## Timing
- Reset values:
  - state=IDLE, `proc_reset`=1.
  - `busy`=`done`=`pass`=0.
  - `error_count`=0, `first_fail_idx`=all-ones, `first_fail_value`=0.
  - `cycle_count`=0, `ctrl_readReg`=0.
- `start` sampled high at edge k in IDLE: RUN is visible from k+1 (`busy`=1, `proc_reset`=0).
- RUN lasts exactly max(CYCLE_LIMIT,1) cycles. CHECK lasts exactly NUM_CHECKS cycles.
- Start-to-`done` latency is max(CYCLE_LIMIT,1)+NUM_CHECKS cycles after the `start` edge.
- Compare timing: each compare uses `data_readReg` sampled at the end of its CHECK cycle, which gives a single-cycle regfile read.
- `reset` high at any point, mid-RUN or mid-CHECK included: next cycle matches the reset values, and partial results are discarded.
- `reset` and `start` high on the same edge: reset wins.
- `error_count` at max value stays at max.

## Configuration
- `REGFILE_CHECKER_STOP_ON_FAIL_EN`:
  - Defined: the first enabled mismatch moves CHECK directly to DONE on the next edge. `error_count`=1, and the remaining entries are not read.
  - Undefined: all NUM_CHECKS entries are always checked, and `error_count` reports the total.

## Test plan
- Stub regfile r1=3, r2=2, r3=6, r5=5, r6=6, r7=7; table matches; CYCLE_LIMIT=60; pulse `start` → `done` exactly 66 cycles after the start edge, `pass`=1, `error_count`=0, `first_fail_idx`=all-ones.
- Same setup, r3 returns 5 and r6 returns 0:
  - Without the macro: `error_count`=2, `first_fail_idx`=2, `first_fail_value`=5, `pass`=0.
  - With the macro: `done` at cycle 63, `error_count`=1.
- r3 wrong but `exp_en[2]`=0 → `pass`=1, and CHECK still takes 6 cycles.
- Assert `reset` at cycle 30 of RUN → next cycle `proc_reset`=1, `busy`=0, `cycle_count`=0. A re-`start` then completes normally in 66 cycles.
- `start` held high for the whole run → a single run only. After `done`, `start` produces one cycle with `proc_reset`=1, then a new RUN, and the result fields are cleared.
- CYCLE_LIMIT=0, NUM_CHECKS=1 → `done` 2 cycles after `start`; `ctrl_readReg`=`exp_reg[0]` during CHECK.
